// File: rtl/uart_rx_pkg.sv
// Shared UART constants, the receiver's output bundle and a majority-vote helper.
// Latency: n/a (package only).
// Backpressure: n/a; the receiver has no flow control.
//
// Contents:
//   UART_CLK_FREQ_DEF / UART_BPS_DEF - defaults shared by the transmitter and uart_rx
//   baud_cnt_max()                   - clocks per bit for a given clock/baud pair
//   maj3()                           - 2-of-3 vote used for mid-bit sampling
//   rx_out_t                         - registered output bundle of uart_rx
package uart_rx_pkg;

    localparam int unsigned UART_CLK_FREQ_DEF = 50_000_000;
    localparam int unsigned UART_BPS_DEF      = 115_200;

    // Integer division truncates: 50 MHz / 115200 gives 434 clocks per bit.
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    typedef struct packed {
        logic [7:0] data;       // last good byte
        logic       done;       // one-cycle strobe: data was just updated
        logic       frame_err;  // one-cycle strobe: stop bit was low
        logic       busy;       // receiver is inside a frame
    } rx_out_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line input and received-byte outputs of the UART receiver.
// Latency: n/a (signal bundle only).
// Backpressure: none; done is a strobe and the consumer must keep up.
//
// Modports:
//   master - line driver / byte consumer side (drives uart_rxd)
//   slave  - the receiver itself (drives the data, strobes and busy)
interface uart_rx_if;
    logic       uart_rxd;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_frame_err;
    logic       uart_rx_busy;

    modport master (
        output uart_rxd,
        input  uart_rx_data,
        input  uart_rx_done,
        input  uart_frame_err,
        input  uart_rx_busy
    );

    modport slave (
        input  uart_rxd,
        output uart_rx_data,
        output uart_rx_done,
        output uart_frame_err,
        output uart_rx_busy
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk from d to q.
// Backpressure: none.
//
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
// RST_VAL is the value both stages take in reset, so a line idling at that
// level shows no transition when reset is released.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] stage_q;
    logic [1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {2{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote at mid-bit.
// Latency: done/frame_err strobe 1 clk after the stop-bit sample point (~mid stop bit).
// Backpressure: none; uart_rx_data holds until the next good frame only.
//
// Ports:
//   clk, rst      - system clock, async active-high reset
//   rx_if.slave   - uart_rxd in; uart_rx_data, uart_rx_done, uart_frame_err, uart_rx_busy out
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = UART_CLK_FREQ_DEF,
    parameter int unsigned UART_BPS = UART_BPS_DEF
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx_if
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] SMP_PT   = CNT_W'(HALF_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer plus one extra stage for edge detection
    // ------------------------------------------------------------------
    logic rxd_sync;
    logic rxd_d3_q;
    logic rxd_d3_d;
    logic fall_edge;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_if.uart_rxd),
        .q   (rxd_sync)
    );

    assign rxd_d3_d  = rxd_sync;
    assign fall_edge = ~rxd_sync & rxd_d3_q;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic [1:0]       vote_q,     vote_d;     // [0] at HALF_CNT-1, [1] at HALF_CNT
    rx_out_t          out_q,      out_d;

    logic baud_wrap;
    logic smp_pt;
    logic bit_val;

    assign baud_wrap = (baud_cnt_q == CNT_LAST);
    assign smp_pt    = (baud_cnt_q == SMP_PT);
    // Third vote is the live synchronized line at the sample point itself.
    assign bit_val   = maj3(vote_q[0], vote_q[1], rxd_sync);

    always_comb begin
        state_d        = state_q;
        baud_cnt_d     = baud_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        vote_d         = vote_q;
        out_d          = out_q;
        out_d.done     = 1'b0;
        out_d.frame_err = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : (baud_cnt_q + CNT_ONE);
            if (baud_cnt_q == SMP_A) vote_d[0] = rxd_sync;
            if (baud_cnt_q == SMP_B) vote_d[1] = rxd_sync;
        end

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (fall_edge) begin
                    state_d   = ST_START;
                    bit_cnt_d = 3'd0;
                end
            end

            ST_START: begin
                if (smp_pt && bit_val) begin
                    // Line went back high before mid start bit: glitch.
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                end else if (baud_wrap) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end

            ST_DATA: begin
                if (smp_pt) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (baud_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                // Leave at mid stop bit so a start bit following immediately
                // after a single stop bit is still caught as a falling edge.
                if (smp_pt) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                    if (bit_val) begin
                        out_d.data = shift_q;
                        out_d.done = 1'b1;
                    end else begin
                        out_d.frame_err = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase

        out_d.busy = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_d3_q   <= 1'b1;
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            vote_q     <= 2'b11;
            out_q      <= '0;
        end else begin
            rxd_d3_q   <= rxd_d3_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            vote_q     <= vote_d;
            out_q      <= out_d;
        end
    end

    assign rx_if.uart_rx_data   = out_q.data;
    assign rx_if.uart_rx_done   = out_q.done;
    assign rx_if.uart_frame_err = out_q.frame_err;
    assign rx_if.uart_rx_busy   = out_q.busy;

endmodule
